mult128_share_arbiter: RTL and testbench
========================================

// Module: mult128_share_arbiter
// PURPOSE
//   Shares one combinational WIDTH x WIDTH multiplier between NUM_REQ requesters.
//   Round-robin arbitration, operand registration, a wait of MUL_LATENCY cycles for multiplier settling,
//   and a registered valid/ready response tagged with the requester id.
//   Sits between client blocks and the multiplier_128bits_* datapath.
//   The multiplier is instantiated beside this block and wired through mul_a/mul_b/mul_product.
// PARAMETERS
//   NUM_REQ      4    number of requesters (2..8)
//   WIDTH        128  operand width; product is 2*WIDTH
//   MUL_LATENCY  1    cycles operands are held before product capture (>=1)
// PORTS
//   clk          in   1               rising-edge clock
//   rst          in   1               asynchronous, active-high reset
//   req_valid    in   NUM_REQ         per-requester operand valid
//   req_a        in   NUM_REQ*WIDTH   operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b        in   NUM_REQ*WIDTH   operand B, same packing
//   req_ready    out  NUM_REQ         one-hot accept strobe (combinational)
//   mul_a        out  WIDTH           registered operand A to multiplier
//   mul_b        out  WIDTH           registered operand B to multiplier
//   mul_product  in   2*WIDTH         multiplier result
//   rsp_valid    out  1               response valid
//   rsp_ready    in   1               response consumer ready
//   rsp_id       out  clog2(NUM_REQ)  index of the requester owning rsp_product
//   rsp_product  out  2*WIDTH         registered product
//   busy         out  1               high in any state other than IDLE
// BEHAVIOUR
// - Reset values (async, immediate):
//   - state=IDLE; mul_a=mul_b=0; rsp_valid=0; rsp_id=0; rsp_product=0; busy=0.
//   - Counter=0; rr_last=NUM_REQ-1, so requester 0 has priority first.
// - FSM states: IDLE -> MUL -> RESP -> IDLE. Exactly one operation is outstanding at a time.
// - IDLE:
//   - grant = first i with req_valid[i]=1, scanning from rr_last+1 mod NUM_REQ upward with wrap.
//   - req_ready[grant]=1 combinationally; all other req_ready bits = 0. req_ready=0 in MUL/RESP.
//   - Handshake completes when req_valid[i] & req_ready[i] at a clock edge.
//   - On that edge: mul_a<=req_a[i]; mul_b<=req_b[i]; rsp_id<=i; rr_last<=i; counter<=0; state<=MUL.
//   - No req_valid set: stay in IDLE; rr_last unchanged.
// - MUL:
//   - mul_a/mul_b are held stable; counter increments each cycle.
//   - On the edge where counter==MUL_LATENCY-1: rsp_product<=mul_product; rsp_valid<=1; state<=RESP.
// - RESP:
//   - rsp_valid, rsp_id and rsp_product are held stable until rsp_ready=1.
//   - On the edge with rsp_valid & rsp_ready: rsp_valid<=0; state<=IDLE.
//   - No new grant is made in the RESP cycle.
// - Latency: accept edge T -> rsp_valid high after edge T+MUL_LATENCY.
// - Minimum issue interval: MUL_LATENCY+2 cycles with rsp_ready tied high.
// - Arithmetic: unsigned. The product is passed through untouched (full 2*WIDTH, no truncation).
// - Requester rules:
//   - A requester that drops req_valid before the handshake completes is not granted and forfeits nothing.
//   - Operands are sampled only on the accept edge; later changes are ignored.
// - Simultaneous requests: exactly one is granted per accept. Each waiting requester is served within NUM_REQ grants.
// - mul_a/mul_b keep their last operands after completion; they are not cleared.
// - Reset mid-operation (MUL or RESP): the in-flight operation is discarded and no response is produced.
//   After reset the arbitration pointer restarts at requester 0.
// TESTING
// 1. Single op: req_valid=0001, A=3, B=5 -> req_ready=0001; product 15 with rsp_valid, rsp_id=0 at T+MUL_LATENCY.
// 2. Max operands: A=B=2^128-1 -> rsp_product = 0xFFFF..FFFE (32 hex digits) followed by 0x0000..0001 (32 hex digits).
// 3. All four requesters valid continuously, rsp_ready=1:
//    - Grant order 0,1,2,3,0.
//    - Each rsp_id matches its grant; issue interval = MUL_LATENCY+2.
// 4. Backpressure: hold rsp_ready=0 for 10 cycles in RESP:
//    - rsp_product/rsp_id stay stable; req_ready stays 0; busy=1.
//    - Release -> IDLE on the next edge.
// 5. Reset mid-MUL: assert rst with req_valid=0010 pending:
//    - rsp_valid never rises; all outputs go to 0 immediately.
//    - After release with req_valid=1010, requester 1 is granted first.
// 6. Repeat tests 1-3 with MUL_LATENCY=3: rsp_valid rises exactly 3 cycles after the accept edge.

Source files
------------

// File: rtl/mult128_share_arbiter.sv
// Round-robin arbiter that shares one external combinational multiplier among NUM_REQ clients.
// It registers the operands, waits MUL_LATENCY cycles, and returns a tagged valid/ready response.
module mult128_share_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned WIDTH       = 128,
  parameter int unsigned MUL_LATENCY = 1
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic [NUM_REQ-1:0]                              req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]                        req_a,
  input  logic [NUM_REQ*WIDTH-1:0]                        req_b,
  output logic [NUM_REQ-1:0]                              req_ready,
  output logic [WIDTH-1:0]                                mul_a,
  output logic [WIDTH-1:0]                                mul_b,
  input  logic [2*WIDTH-1:0]                              mul_product,
  output logic                                            rsp_valid,
  input  logic                                            rsp_ready,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] rsp_id,
  output logic [2*WIDTH-1:0]                              rsp_product,
  output logic                                            busy
);

  localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW  = $clog2(MUL_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, MUL, RESP} state_t;

  state_t           state;
  logic [IDW-1:0]   rr_last;
  logic [CW-1:0]    counter;
  logic             gnt_found;
  logic [IDW-1:0]   gnt_idx;
  logic [IDW-1:0]   scan_sel;
  int unsigned      scan_idx;
  logic [WIDTH-1:0] a_arr [NUM_REQ];
  logic [WIDTH-1:0] b_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[g*WIDTH +: WIDTH];
    assign b_arr[g] = req_b[g*WIDTH +: WIDTH];
  end

  // First valid requester after rr_last, wrapping around.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = 0;
    scan_sel  = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      scan_idx = 32'(rr_last) + k;
      if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
      scan_sel = IDW'(scan_idx);
      if (!gnt_found && req_valid[scan_sel]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_sel;
      end
    end
  end

  // Accept strobe is offered only while idle and out of reset.
  always_comb begin
    req_ready = '0;
    if (!rst && state == IDLE && gnt_found) req_ready[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr_last     <= IDW'(NUM_REQ - 1);
      counter     <= '0;
      mul_a       <= '0;
      mul_b       <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_product <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_found) begin
            mul_a   <= a_arr[gnt_idx];
            mul_b   <= b_arr[gnt_idx];
            rsp_id  <= gnt_idx;
            rr_last <= gnt_idx;
            counter <= '0;
            busy    <= 1'b1;
            state   <= MUL;
          end
        end
        MUL: begin
          counter <= counter + CW'(1);
          if (counter == CW'(MUL_LATENCY - 1)) begin
            rsp_product <= mul_product;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult128_share_arbiter.sv
// Directed bench for mult128_share_arbiter: one instance with MUL_LATENCY=1 and one with MUL_LATENCY=3.
// The external multiplier is modelled behaviourally; all expected products are hand-computed constants.
module tb_mult128_share_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned W = 128;

  logic           clk = 1'b0;
  logic           rst;
  int             checks = 0;
  int             errors = 0;

  logic [N-1:0]   req_valid, req_ready, req_valid3, req_ready3;
  logic [N*W-1:0] req_a, req_b, req_a3, req_b3;
  logic [W-1:0]   mul_a, mul_b, mul_a3, mul_b3;
  logic [2*W-1:0] mul_product, mul_product3, rsp_product, rsp_product3;
  logic           rsp_valid, rsp_ready, busy, rsp_valid3, rsp_ready3, busy3;
  logic [1:0]     rsp_id, rsp_id3;

  logic [W-1:0]   ones;
  logic [2*W-1:0] maxp;
  logic [2*W-1:0] rr_prod [4];

  always #5 clk = ~clk;

  assign mul_product  = {{W{1'b0}}, mul_a}  * {{W{1'b0}}, mul_b};
  assign mul_product3 = {{W{1'b0}}, mul_a3} * {{W{1'b0}}, mul_b3};

  mult128_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .MUL_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_product(mul_product),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_product(rsp_product), .busy(busy));

  mult128_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .MUL_LATENCY(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid3), .req_a(req_a3), .req_b(req_b3),
    .req_ready(req_ready3), .mul_a(mul_a3), .mul_b(mul_b3), .mul_product(mul_product3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_id(rsp_id3),
    .rsp_product(rsp_product3), .busy(busy3));

  task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    ones = {W{1'b1}};
    maxp = {{(W-1){1'b1}}, 1'b0, {(W-1){1'b0}}, 1'b1};
    rr_prod[0] = 256'd20; rr_prod[1] = 256'd60; rr_prod[2] = 256'd120; rr_prod[3] = 256'd200;
    rst = 1'b1; rsp_ready = 1'b1; rsp_ready3 = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0;
    req_valid3 = '0; req_a3 = '0; req_b3 = '0;
    tick(); tick();

    // Reset state
    chk("rst_rsp_valid", 256'(rsp_valid), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_mul_a", 256'(mul_a), 256'(0));
    chk("rst_rsp_id", 256'(rsp_id), 256'(0));
    chk("rst_rsp_product", rsp_product, 256'(0));
    chk("rst_req_ready", 256'(req_ready), 256'(0));
    rst = 1'b0;
    tick();

    // Single op on requester 0; operand changes after accept must be ignored
    req_valid = 4'b0001; req_a[0 +: W] = 128'd3; req_b[0 +: W] = 128'd5;
    #1 chk("t1_req_ready", 256'(req_ready), 256'(4'b0001));
    tick();
    chk("t1_busy_mul", 256'(busy), 256'(1));
    chk("t1_ready_mul", 256'(req_ready), 256'(0));
    chk("t1_mul_a", 256'(mul_a), 256'(3));
    chk("t1_valid_early", 256'(rsp_valid), 256'(0));
    req_valid = '0; req_a[0 +: W] = 128'd7;
    tick();
    chk("t1_rsp_valid", 256'(rsp_valid), 256'(1));
    chk("t1_rsp_product", rsp_product, 256'(15));
    chk("t1_rsp_id", 256'(rsp_id), 256'(0));
    tick();
    chk("t1_valid_drop", 256'(rsp_valid), 256'(0));
    chk("t1_busy_idle", 256'(busy), 256'(0));
    chk("t1_mul_a_kept", 256'(mul_a), 256'(3));

    // Max operands on requester 3
    req_valid = 4'b1000; req_a[3*W +: W] = ones; req_b[3*W +: W] = ones;
    #1 chk("t2_req_ready", 256'(req_ready), 256'(4'b1000));
    tick();
    req_valid = '0;
    tick();
    chk("t2_rsp_valid", 256'(rsp_valid), 256'(1));
    chk("t2_rsp_product", rsp_product, maxp);
    chk("t2_rsp_id", 256'(rsp_id), 256'(3));
    tick();

    // All requesters valid: grants 0,1,2,3,0 every 3 cycles
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = W'(i + 2);
      req_b[i*W +: W] = W'(10 * (i + 1));
    end
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1 chk($sformatf("t3_grant%0d", k), 256'(req_ready), 256'(4'b0001 << (k % 4)));
      tick();
      chk($sformatf("t3_ready_mul%0d", k), 256'(req_ready), 256'(0));
      tick();
      chk($sformatf("t3_valid%0d", k), 256'(rsp_valid), 256'(1));
      chk($sformatf("t3_id%0d", k), 256'(rsp_id), 256'(k % 4));
      chk($sformatf("t3_prod%0d", k), rsp_product, rr_prod[k % 4]);
      chk($sformatf("t3_ready_resp%0d", k), 256'(req_ready), 256'(0));
      tick();
    end
    req_valid = '0;
    tick();

    // Backpressure: 10 cycles with rsp_ready low while requester 2 keeps asking
    rsp_ready = 1'b0;
    req_valid = 4'b0100; req_a[2*W +: W] = 128'd6; req_b[2*W +: W] = 128'd7;
    tick(); tick();
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("t4_valid%0d", k), 256'(rsp_valid), 256'(1));
      chk($sformatf("t4_prod%0d", k), rsp_product, 256'(42));
      chk($sformatf("t4_id%0d", k), 256'(rsp_id), 256'(2));
      chk($sformatf("t4_ready%0d", k), 256'(req_ready), 256'(0));
      chk($sformatf("t4_busy%0d", k), 256'(busy), 256'(1));
      tick();
    end
    rsp_ready = 1'b1; req_valid = '0;
    tick();
    chk("t4_release_valid", 256'(rsp_valid), 256'(0));
    chk("t4_release_busy", 256'(busy), 256'(0));

    // Reset mid-MUL discards the operation and restarts round-robin at 0
    req_valid = 4'b0010; req_a[1*W +: W] = 128'd9; req_b[1*W +: W] = 128'd9;
    tick();
    chk("t5_busy_before", 256'(busy), 256'(1));
    rst = 1'b1;
    #1;
    chk("t5_busy", 256'(busy), 256'(0));
    chk("t5_mul_a", 256'(mul_a), 256'(0));
    chk("t5_rsp_id", 256'(rsp_id), 256'(0));
    chk("t5_rsp_product", rsp_product, 256'(0));
    chk("t5_req_ready", 256'(req_ready), 256'(0));
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("t5_no_valid%0d", k), 256'(rsp_valid), 256'(0));
    end
    req_a[3*W +: W] = 128'd2; req_b[3*W +: W] = 128'd11;
    req_valid = 4'b1010;
    rst = 1'b0;
    #1 chk("t5_first_grant", 256'(req_ready), 256'(4'b0010));
    tick(); tick();
    chk("t5_rsp_id", 256'(rsp_id), 256'(1));
    chk("t5_rsp_product", rsp_product, 256'(81));
    tick();
    #1 chk("t5_second_grant", 256'(req_ready), 256'(4'b1000));
    req_valid = '0;
    tick();

    // MUL_LATENCY=3 instance: single op, max operands, round-robin every 5 cycles
    req_valid3 = 4'b0001; req_a3[0 +: W] = 128'd3; req_b3[0 +: W] = 128'd5;
    #1 chk("t6_req_ready", 256'(req_ready3), 256'(4'b0001));
    tick();
    req_valid3 = '0;
    tick(); chk("t6_valid_t1", 256'(rsp_valid3), 256'(0));
    tick(); chk("t6_valid_t2", 256'(rsp_valid3), 256'(0));
    tick();
    chk("t6_valid_t3", 256'(rsp_valid3), 256'(1));
    chk("t6_product", rsp_product3, 256'(15));
    chk("t6_id", 256'(rsp_id3), 256'(0));
    tick();
    req_valid3 = 4'b1000; req_a3[3*W +: W] = ones; req_b3[3*W +: W] = ones;
    tick();
    req_valid3 = '0;
    tick(); tick(); tick();
    chk("t6_max_valid", 256'(rsp_valid3), 256'(1));
    chk("t6_max_product", rsp_product3, maxp);
    chk("t6_max_id", 256'(rsp_id3), 256'(3));
    tick();
    for (int i = 0; i < N; i++) begin
      req_a3[i*W +: W] = W'(i + 2);
      req_b3[i*W +: W] = W'(10 * (i + 1));
    end
    req_valid3 = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1 chk($sformatf("t6_grant%0d", k), 256'(req_ready3), 256'(4'b0001 << (k % 4)));
      tick(); tick(); tick();
      chk($sformatf("t6_early%0d", k), 256'(rsp_valid3), 256'(0));
      tick();
      chk($sformatf("t6_rr_valid%0d", k), 256'(rsp_valid3), 256'(1));
      chk($sformatf("t6_rr_id%0d", k), 256'(rsp_id3), 256'(k % 4));
      chk($sformatf("t6_rr_prod%0d", k), rsp_product3, rr_prod[k % 4]);
      tick();
    end
    req_valid3 = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
